// File: rtl/decode_pkg.sv
// Shared encodings for the registered RV32 decode stage: opcodes, funct fields,
// ALU op / writeback-select enums and the control bundle carried to execute.
package decode_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_CSRRW   = 3'b001;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_XOR   = 4'b0010,
        ALU_ADD   = 4'b0011,
        ALU_SUB   = 4'b0100,
        ALU_MUL   = 4'b0101,
        ALU_MULH  = 4'b0110,
        ALU_MULHU = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_SLT   = 4'b1100,
        ALU_SLTU  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        RS_GPIO = 2'b00,
        RS_IMM  = 2'b01,
        RS_ALU  = 2'b10
    } regsel_e;

    // imm is kept at 32 bits; every immediate form has a meaningful bit 31,
    // so the top sign-extends it to XLEN.
    typedef struct packed {
        logic        alusrc;
        logic        regwrite;
        regsel_e     regsel;
        alu_op_e     op;
        logic        gpio_we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    function automatic logic is_mul(input alu_op_e o);
        return (o == ALU_MUL) || (o == ALU_MULH) || (o == ALU_MULHU);
    endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32 decode: instruction word to control bundle,
// plus a flag telling the pipeline stage the beat needs the multiply hold.
module rv_decode_comb
    import decode_pkg::*;
#(
    parameter logic [11:0] GPIO_IN_CSR  = 12'hF00,
    parameter logic [11:0] GPIO_OUT_CSR = 12'hF02
) (
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        mul
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] csr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign csr    = instr[31:20];

    always_comb begin
        ctrl.alusrc   = 1'b0;
        ctrl.regwrite = 1'b0;
        ctrl.regsel   = RS_GPIO;
        ctrl.op       = ALU_AND;
        ctrl.gpio_we  = 1'b0;
        ctrl.rd       = instr[11:7];
        ctrl.rs1      = instr[19:15];
        ctrl.rs2      = instr[24:20];
        ctrl.imm      = '0;
        ctrl.illegal  = 1'b0;

        case (opcode)
            OPC_OP: begin
                ctrl.regsel   = RS_ALU;
                ctrl.regwrite = 1'b1;
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            F3_ADD_SUB: ctrl.op = ALU_ADD;
                            F3_SLL:     ctrl.op = ALU_SLL;
                            F3_SLT:     ctrl.op = ALU_SLT;
                            F3_SLTU:    ctrl.op = ALU_SLTU;
                            F3_XOR:     ctrl.op = ALU_XOR;
                            F3_SRL_SRA: ctrl.op = ALU_SRL;
                            F3_OR:      ctrl.op = ALU_OR;
                            default:    ctrl.op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == F3_ADD_SUB)      ctrl.op = ALU_SUB;
                        else if (funct3 == F3_SRL_SRA) ctrl.op = ALU_SRA;
                        else                           ctrl.illegal = 1'b1;
                    end
                    F7_MULDIV: begin
                        case (funct3)
                            F3_MUL:   ctrl.op = ALU_MUL;
                            F3_MULH:  ctrl.op = ALU_MULH;
                            F3_MULHU: ctrl.op = ALU_MULHU;
                            default:  ctrl.illegal = 1'b1;
                        endcase
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regsel   = RS_ALU;
                ctrl.regwrite = 1'b1;
                ctrl.imm      = {{20{instr[31]}}, instr[31:20]};
                case (funct3)
                    F3_ADD_SUB: ctrl.op = ALU_ADD;
                    F3_XOR:     ctrl.op = ALU_XOR;
                    F3_OR:      ctrl.op = ALU_OR;
                    F3_AND:     ctrl.op = ALU_AND;
                    // Shifts carry an unsigned shamt; the upper bits select the shift kind.
                    F3_SLL: begin
                        ctrl.op  = ALU_SLL;
                        ctrl.imm = {27'b0, instr[24:20]};
                        if (funct7 != F7_BASE) ctrl.illegal = 1'b1;
                    end
                    F3_SRL_SRA: begin
                        ctrl.imm = {27'b0, instr[24:20]};
                        if (funct7 == F7_BASE)     ctrl.op = ALU_SRL;
                        else if (funct7 == F7_ALT) ctrl.op = ALU_SRA;
                        else                       ctrl.illegal = 1'b1;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                ctrl.regsel   = RS_IMM;
                ctrl.regwrite = 1'b1;
                ctrl.imm      = {instr[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                if (funct3 == F3_CSRRW && csr == GPIO_OUT_CSR) begin
                    ctrl.gpio_we = 1'b1;
                end else if (funct3 == F3_CSRRW && csr == GPIO_IN_CSR) begin
                    ctrl.regsel   = RS_GPIO;
                    ctrl.regwrite = 1'b1;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            default: ctrl.illegal = 1'b1;
        endcase

        if (ctrl.illegal) begin
            ctrl.regwrite = 1'b0;
            ctrl.gpio_we  = 1'b0;
        end
        if (ctrl.rd == 5'd0) ctrl.regwrite = 1'b0;
    end

    assign mul = is_mul(ctrl.op) && !ctrl.illegal;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered, valid/ready decode stage: holds one decoded bundle, stretches
// multiplies over MUL_CYCLES before presenting them to execute.
module decode_ctrl_pipe
    import decode_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter int          MUL_CYCLES   = 3,
    parameter logic [11:0] GPIO_IN_CSR  = 12'hF00,
    parameter logic [11:0] GPIO_OUT_CSR = 12'hF02
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            alusrc,
    output logic            regwrite,
    output logic [1:0]      regsel,
    output logic [3:0]      op,
    output logic            gpio_we,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        MULWAIT = 2'b10
    } state_e;

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    state_e             state;
    logic [CW-1:0]      cnt;
    logic               ready_en;
    ctrl_t              bundle;
    ctrl_t              dec;
    logic               dec_mul;
    logic               accept;
    logic signed [31:0] imm32;

    rv_decode_comb #(
        .GPIO_IN_CSR (GPIO_IN_CSR),
        .GPIO_OUT_CSR(GPIO_OUT_CSR)
    ) u_decode (
        .instr(instr),
        .ctrl (dec),
        .mul  (dec_mul)
    );

    // ready_en keeps in_ready low through reset and for the first edge after it.
    assign in_ready = ready_en && ((state == IDLE) || (state == HOLD && out_ready));
    assign accept   = in_valid && in_ready;

    // A multiply waits MUL_CYCLES-1 cycles in MULWAIT; the last decrement lands in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ready_en <= 1'b0;
            bundle   <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        bundle <= dec;
                        if (dec_mul && MUL_CYCLES > 1) begin
                            state <= MULWAIT;
                            cnt   <= CW'(MUL_CYCLES - 1);
                        end else begin
                            state <= HOLD;
                        end
                    end else if (state == HOLD && out_ready) begin
                        state <= IDLE;
                    end
                end
                MULWAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= CW'(1)) state <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == HOLD);
    assign alusrc    = bundle.alusrc;
    assign regwrite  = bundle.regwrite;
    assign regsel    = bundle.regsel;
    assign op        = bundle.op;
    assign gpio_we   = bundle.gpio_we;
    assign rd        = bundle.rd;
    assign rs1       = bundle.rs1;
    assign rs2       = bundle.rs2;
    assign illegal   = bundle.illegal;
    assign imm32     = bundle.imm;
    assign imm       = XLEN'(imm32);

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed-vector bench for decode_ctrl_pipe: reset, streaming, stalls,
// multiply hold, CSR/LUI decode and illegal encodings.
module tb_decode_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        alusrc;
    logic        regwrite;
    logic [1:0]  regsel;
    logic [3:0]  op;
    logic        gpio_we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    decode_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .alusrc(alusrc), .regwrite(regwrite), .regsel(regsel), .op(op),
        .gpio_we(gpio_we), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .illegal(illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] word);
        instr     = word;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0h want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready got=%0h want=0", in_ready); end
        total++; if ({alusrc, regwrite, regsel, op, gpio_we, illegal} !== 10'd0) begin bad++; $display("[TB] FAIL reset_ctrl got=%0h want=0", {alusrc, regwrite, regsel, op, gpio_we, illegal}); end
        total++; if ({rd, rs1, rs2, imm} !== 47'd0) begin bad++; $display("[TB] FAIL reset_fields got=%0h want=0", {rd, rs1, rs2, imm}); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL release_in_ready_early got=%0h want=0", in_ready); end
        step();
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_in_ready got=%0h want=1", in_ready); end
    endtask

    task automatic test_addi_stream();
        logic [31:0] words [4];
        logic [3:0]  ops [4];
        logic [4:0]  rds [4];
        logic [31:0] imms [4];
        words = '{32'h00500093, 32'hFFF00113, 32'h00F0C213, 32'h4030D293};
        ops   = '{4'b0011, 4'b0011, 4'b0010, 4'b1010};
        rds   = '{5'd1, 5'd2, 5'd4, 5'd5};
        imms  = '{32'd5, 32'hFFFFFFFF, 32'h0000000F, 32'd3};
        send_one(32'h00500093);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addi_valid got=%0h want=1", out_valid); end
        total++; if ({alusrc, regwrite, regsel, op} !== {1'b1, 1'b1, 2'b10, 4'b0011}) begin bad++; $display("[TB] FAIL addi_ctrl got=%0h want=%0h", {alusrc, regwrite, regsel, op}, {1'b1, 1'b1, 2'b10, 4'b0011}); end
        total++; if (rd !== 5'd1 || imm !== 32'd5 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL addi_fields got rd=%0d imm=%0h ill=%0h want rd=1 imm=5 ill=0", rd, imm, illegal); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addi_single_beat got=%0h want=0", out_valid); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            instr = words[i];
            total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_in_ready[%0d] got=%0h want=1", i, in_ready); end
            step();
            total++; if (out_valid !== 1'b1 || op !== ops[i] || rd !== rds[i] || imm !== imms[i]) begin
                bad++; $display("[TB] FAIL stream_beat[%0d] got v=%0h op=%0h rd=%0d imm=%0h want v=1 op=%0h rd=%0d imm=%0h", i, out_valid, op, rd, imm, ops[i], rds[i], imms[i]);
            end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_drain got=%0h want=0", out_valid); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        instr     = 32'h402081B3;
        in_valid  = 1'b1;
        step();
        instr = 32'h00500093;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || op !== 4'b0100 || rd !== 5'd3 || in_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL stall_hold[%0d] got v=%0h op=%0h rd=%0d rdy=%0h want v=1 op=4 rd=3 rdy=0", i, out_valid, op, rd, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release_ready got=%0h want=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || op !== 4'b0011 || rd !== 5'd1) begin bad++; $display("[TB] FAIL stall_swap got v=%0h op=%0h rd=%0d want v=1 op=3 rd=1", out_valid, op, rd); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_drain got=%0h want=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL ready_while_empty got=%0h want=0", out_valid); end
    endtask

    task automatic test_mul();
        send_one(32'h022081B3);
        for (int i = 0; i < 2; i++) begin
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mul_wait[%0d] got v=%0h rdy=%0h want v=0 rdy=0", i, out_valid, in_ready); end
            step();
        end
        total++; if (out_valid !== 1'b1 || op !== 4'b0101 || rd !== 5'd3 || regwrite !== 1'b1) begin bad++; $display("[TB] FAIL mul_beat got v=%0h op=%0h rd=%0d rw=%0h want v=1 op=5 rd=3 rw=1", out_valid, op, rd, regwrite); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mul_drain got=%0h want=0", out_valid); end
        send_one(32'h022081B3);
        step();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || op !== 4'b0000 || rd !== 5'd0 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mul_reset got v=%0h op=%0h rd=%0d rdy=%0h want all 0", out_valid, op, rd, in_ready); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mul_after_reset[%0d] got=%0h want=0", i, out_valid); end
        end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mul_after_reset_ready got=%0h want=1", in_ready); end
    endtask

    task automatic test_csr_lui();
        send_one(32'hF0229073);
        total++; if (gpio_we !== 1'b1 || regwrite !== 1'b0 || rs1 !== 5'd5 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL csr_out got we=%0h rw=%0h rs1=%0d ill=%0h want we=1 rw=0 rs1=5 ill=0", gpio_we, regwrite, rs1, illegal); end
        send_one(32'hF00013F3);
        total++; if (regsel !== 2'b00 || regwrite !== 1'b1 || gpio_we !== 1'b0 || rd !== 5'd7) begin bad++; $display("[TB] FAIL csr_in got sel=%0h rw=%0h we=%0h rd=%0d want sel=0 rw=1 we=0 rd=7", regsel, regwrite, gpio_we, rd); end
        send_one(32'h12345137);
        total++; if (regsel !== 2'b01 || imm !== 32'h12345000 || regwrite !== 1'b1 || alusrc !== 1'b0 || op !== 4'b0000 || rd !== 5'd2) begin
            bad++; $display("[TB] FAIL lui got sel=%0h imm=%0h rw=%0h as=%0h op=%0h rd=%0d want sel=1 imm=12345000 rw=1 as=0 op=0 rd=2", regsel, imm, regwrite, alusrc, op, rd);
        end
        send_one(32'h00208033);
        total++; if (regwrite !== 1'b0 || illegal !== 1'b0 || op !== 4'b0011) begin bad++; $display("[TB] FAIL add_x0 got rw=%0h ill=%0h op=%0h want rw=0 ill=0 op=3", regwrite, illegal, op); end
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        words = '{32'hFFFFFFFF, 32'h40109093, 32'h00129073};
        for (int i = 0; i < 3; i++) begin
            send_one(words[i]);
            total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || regwrite !== 1'b0 || gpio_we !== 1'b0) begin
                bad++; $display("[TB] FAIL illegal[%0d] got v=%0h ill=%0h rw=%0h we=%0h want v=1 ill=1 rw=0 we=0", i, out_valid, illegal, regwrite, gpio_we);
            end
            step();
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL illegal_one_beat[%0d] got=%0h want=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_addi_stream();
        test_stall();
        test_mul();
        test_csr_lui();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
Registered, handshaked successor to the single-cycle RV32 control unit. Decodes one 32-bit instruction per accepted beat into ALU/writeback/GPIO control plus extracted register indices and immediate, and holds them in an output stage with valid/ready flow control. Sits between the fetch/instruction register and the execute/writeback stage. Adds a multi-cycle hold for the M-extension multiply, CSRRW-based GPIO access and an illegal-instruction flag.

Parameters:
XLEN, 32, datapath and immediate width (at least 32)
MUL_CYCLES, 3, execute cycles a mul/mulh/mulhu occupies (at least 1)
GPIO_IN_CSR, 12'hF00, CSR address whose CSRRW reads gpio_in
GPIO_OUT_CSR, 12'hF02, CSR address whose CSRRW writes gpio_out

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instr is valid
in_ready  out  1  block accepts instr this cycle
instr  in  32  RV32 instruction word
out_valid  out  1  decoded control bundle is valid
out_ready  in  1  execute stage consumes the bundle
alusrc  out  1  1 selects imm as ALU operand B, 0 selects rs2 data
regwrite  out  1  register-file write enable
regsel  out  2  writeback source: 00 gpio_in, 01 imm (lui), 10 ALU result
op  out  4  ALU operation
gpio_we  out  1  load gpio_out from rs1 data
rd, rs1, rs2  out  5 each  register indices
imm  out  XLEN  sign- or zero-extended immediate
illegal  out  1  instruction not recognised

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All state and outputs go to 0 during reset: out_valid, every control bit, op, rd/rs1/rs2, imm, illegal, the state machine and the multiply counter. in_ready is 0 while rst_n is low and goes to 1 on the first clock after reset is released.
- op encoding:
  - and 0000, or 0001, xor 0010, add 0011, sub 0100
  - mul 0101, mulh 0110, mulhu 0111
  - sll 1000, srl 1001, sra 1010, slt 1100, sltu 1101
- Decoded instructions:
  - R-type (alusrc=0, regsel=10): add, sub, and, or, xor, sll, srl, sra, slt, sltu, mul, mulh, mulhu.
  - I-type (alusrc=1, regsel=10): addi, andi, ori, xori, slli, srli, srai.
  - lui: regsel=01, alusrc=0, op=0000.
- Immediates:
  - I-type: instr[31:20] sign-extended to XLEN.
  - Shift-immediates: zero-extended shamt instr[24:20]; bits [31:25] must be 0000000 (0100000 for srai), otherwise illegal.
  - lui: {instr[31:12], 12'b0}, sign-extended to XLEN.
- csrrw (opcode 1110011, funct3 001):
  - csr == GPIO_OUT_CSR: gpio_we=1, regwrite=0.
  - csr == GPIO_IN_CSR: regsel=00, regwrite=(rd != 0).
  - Any other csr: illegal.
- Illegal instruction (any other encoding): regwrite=0, gpio_we=0, illegal=1. It is still presented as one normal output beat.
- regwrite is forced to 0 whenever rd == 0.
- Latency: decode is registered. A beat accepted at edge N has out_valid=1 after edge N, for non-multiply ops.
- Handshake rules:
  - Accept when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Back-to-back accepts are allowed with no bubble.
  - Outputs stay stable while out_valid && !out_ready.
- State machine:
  - IDLE, no bundle held: accept non-multiply → HOLD; accept multiply → MULWAIT with cnt = MUL_CYCLES-1.
  - HOLD, out_valid=1: on transfer with no new accept → IDLE; transfer plus accept → HOLD, or MULWAIT for a multiply.
  - MULWAIT: out_valid=0, in_ready=0, cnt decrements each cycle; the fields are already registered. At cnt==0 → HOLD on the next edge.
  - MUL_CYCLES=1 skips MULWAIT: a multiply goes straight to HOLD.
- Boundary conditions:
  - in_valid held without a transfer is not re-accepted.
  - out_ready while out_valid=0 is ignored.
  - Reset asserted mid-MULWAIT or mid-HOLD discards the bundle immediately; nothing is emitted after release.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OP_IMM 0010011, OP 0110011, LUI 0110111, SYSTEM 1110011
  - funct3/funct7 constants
  - an alu_op_e enum carrying the op encodings
  - a regsel_e enum
  - a ctrl_t struct holding the full output bundle
- One combinational sub-module, rv_decode_comb (instr → ctrl_t), carries all decode. The top contains only the output register, FSM and counter.

Test Plan:
- Reset: rst_n low for 3 cycles → all outputs 0, in_ready=0; release → in_ready=1 next cycle.
- addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, alusrc=1, regwrite=1, regsel=10, op=0011, rd=1, imm=5; stream of 4 instructions → 4 consecutive out beats.
- sub x3,x1,x2 (0x402081B3) with out_ready=0 for 5 cycles → out_valid and op=0100 held stable; in_ready=0 throughout; transfer and next accept occur on the same edge.
- mul x3,x1,x2 (0x022081B3), MUL_CYCLES=3 → in_ready=0 and out_valid=0 for 2 cycles, then out_valid=1 with op=0101; asserting rst_n=0 during a second mul → no beat emitted.
- csrrw x0,0xF02,x5 (0xF0229073) → gpio_we=1, regwrite=0, rs1=5; lui x2,0x12345 (0x12345137) → regsel=01, imm=0x12345000.
- 0xFFFFFFFF and slli carrying funct7=0100000 → illegal=1, regwrite=0, gpio_we=0, one beat each.
